alu_comp_bectrl: RTL and testbench
==================================

ALU_COMP_BECTRL -- requirements
Module: alu_comp_bectrl

Interface
REQ-001 Parameter: DATA_W, default 32, datapath width; only 32 is supported.
REQ-002 Port: clk  input  1  clock; one clock domain; the block holds no state, so clk is unused.
REQ-003 Port: rst  input  1  reset; synchronous, active-high; no internal state to reset.
REQ-004 Port: alu_a  input  32  ALU operand A; also the shift amount source, bits [4:0].
REQ-005 Port: alu_b  input  32  ALU operand B.
REQ-006 Port: alu_ctrl  input  4  ALU operation select.
REQ-007 Port: alu_out  output  32  ALU result.
REQ-008 Port: comp_a  input  32  branch compare operand A.
REQ-009 Port: comp_b  input  32  branch compare operand B.
REQ-010 Port: comp_op  input  3  branch condition select.
REQ-011 Port: comp_true  output  1  branch condition holds.
REQ-012 Port: be_addr  input  2  byte offset of the memory address.
REQ-013 Port: is_half  input  1  halfword access (LH/LHU/SH).
REQ-014 Port: is_byte  input  1  byte access (LB/LBU/SB).
REQ-015 Port: be_out  output  4  byte enables; bit i enables byte i, bits [8i+7:8i].

Function
REQ-016 All outputs SHALL be purely combinational functions of the current inputs, with zero-cycle latency.
REQ-017 alu_ctrl SHALL select the operation as follows:
- 0000 ADD: A+B, wrapping modulo 2^32, no overflow flag.
- 0001 SUB: A-B, wrapping.
- 0010 AND; 0011 OR; 0100 XOR; 0101 NOR.
- 0110 SLT: 1 if A<B signed, else 0.
- 0111 SLTU: 1 if A<B unsigned, else 0.
- 1000 SLL: B shifted left by A[4:0].
- 1001 SRL: B shifted right logically by A[4:0].
- 1010 SRA: B shifted right arithmetically by A[4:0].
- 1011 LUI: B shifted left by 16.
- 1100 PASSB: B (used for MFHI/MFLO).
- 1101..1111: result 0.
REQ-018 Shifts SHALL ignore alu_a[31:5]; a shift amount of 0 SHALL return B unchanged.
REQ-019 comp_op SHALL select the condition as follows:
- 000 BEQ: A==B.
- 001 BNE: A!=B.
- 010 BLEZ: A<=0 signed.
- 011 BGTZ: A>0 signed.
- 100 BLTZ: A<0 signed.
- 101 BGEZ: A>=0 signed.
- 110 and 111: comp_true is 0.
REQ-020 BLEZ, BGTZ, BLTZ and BGEZ SHALL ignore comp_b.
REQ-021 be_out SHALL follow this rule:
- is_byte=1: be_out = 0001 shifted left by be_addr.
- else is_half=1: be_out = 0011 if be_addr[1]=0, else 1100.
- else: word access, 1111.
REQ-022 is_byte SHALL take priority over is_half when both are 1.
REQ-023 For halfword accesses, be_addr[0] SHALL be ignored; misalignment is not flagged.
REQ-024 For word accesses, be_addr SHALL be ignored.
REQ-025 No X SHALL propagate to outputs for any defined input combination; every case statement has a default.

Reset
REQ-026 rst SHALL have no effect on any output, because the block is stateless.
REQ-027 During reset, outputs SHALL continue to track their inputs per REQ-017 to REQ-024.

Structure
REQ-028 alu_ctrl encodings, comp_op encodings and be_out patterns SHALL be named constants in the shared package mips_pkg, which the decoder also uses.
REQ-029 The condition evaluator SHALL be one natural sub-module, branch_comp.
REQ-030 The ALU and byte-enable logic SHALL remain inline.
REQ-031 The implementation SHALL contain no latches and no clocked processes.

Verification
REQ-032 ALU arithmetic, with alu_a=0x7FFFFFFF and alu_b=0x00000001:
- ADD -> 0x80000000.
- SUB -> 0x7FFFFFFE.
- SLT with alu_a=0xFFFFFFFF, alu_b=1 -> 1.
- SLTU with the same operands -> 0.
REQ-033 ALU shifts:
- alu_b=0x80000010, alu_a=4, SRA -> 0xF8000001; SRL -> 0x08000001; SLL -> 0x00000100.
- alu_a=0xFFFFFFE0 (shift amount 0), SLL -> 0x80000010.
REQ-034 ALU LUI and PASSB:
- alu_b=0x00001234, LUI -> 0x12340000.
- alu_b=0xDEADBEEF, PASSB -> 0xDEADBEEF.
- alu_ctrl=1111 -> 0.
REQ-035 Comparator, with comp_a=0x80000000:
- BLTZ -> 1; BGEZ -> 0; BLEZ -> 1; BGTZ -> 0.
- comp_a=0 -> BLEZ 1, BGEZ 1, BGTZ 0.
- comp_a=comp_b=5 -> BEQ 1, BNE 0.
- comp_op=111 -> 0.
REQ-036 Byte enables:
- is_byte=1 with be_addr=0,1,2,3 -> 0001, 0010, 0100, 1000.
- is_half=1 with be_addr=2 or 3 -> 1100.
- is_half=1 with be_addr=0 -> 0011.
- neither set -> 1111.
- both set with be_addr=2 -> 0100.
REQ-037 Reset transparency: assert rst for 3 cycles while applying the REQ-032 stimulus; outputs SHALL match REQ-032 on every cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: ALU operation selects, branch conditions, byte-enable patterns.
// Constants only; no logic, no latency, no handshake.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_NOR   = 4'b0101;
  localparam logic [3:0] ALU_SLT   = 4'b0110;
  localparam logic [3:0] ALU_SLTU  = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_LUI   = 4'b1011;
  localparam logic [3:0] ALU_PASSB = 4'b1100;

  localparam logic [2:0] CMP_BEQ  = 3'b000;
  localparam logic [2:0] CMP_BNE  = 3'b001;
  localparam logic [2:0] CMP_BLEZ = 3'b010;
  localparam logic [2:0] CMP_BGTZ = 3'b011;
  localparam logic [2:0] CMP_BLTZ = 3'b100;
  localparam logic [2:0] CMP_BGEZ = 3'b101;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/branch_comp.sv
// Branch condition evaluator: equality and sign-of-A tests selected by condOp.
// Latency: combinational; no handshake, so no backpressure.
module branch_comp
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [2:0]      condOp,
  output logic            condTrue
);

  logic aNeg;
  logic aZero;

  assign aNeg  = opA[XLEN-1];
  assign aZero = (opA == '0);

  // Zero-compare conditions look only at opA's sign and zero flags.
  always_comb begin
    condTrue = 1'b0;
    case (condOp)
      CMP_BEQ:  condTrue = (opA == opB);
      CMP_BNE:  condTrue = (opA != opB);
      CMP_BLEZ: condTrue = aNeg | aZero;
      CMP_BGTZ: condTrue = ~aNeg & ~aZero;
      CMP_BLTZ: condTrue = aNeg;
      CMP_BGEZ: condTrue = ~aNeg;
      default:  condTrue = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_comp_bectrl.sv
// MIPS execute helpers: ALU, branch comparator and load/store byte-enable generator.
// Latency: zero cycles, purely combinational; no handshake, so no backpressure.
module alu_comp_bectrl
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] comp_a,
  input  logic [DATA_W-1:0] comp_b,
  input  logic [2:0]        comp_op,
  output logic              comp_true,
  input  logic [1:0]        be_addr,
  input  logic              is_half,
  input  logic              is_byte,
  output logic [3:0]        be_out
);

  logic [4:0] shamt;
  logic       sltBit;
  logic       sltuBit;

  // The block is stateless: clock and reset are accepted only for interface uniformity.
  logic unusedClkRst;
  assign unusedClkRst = clk ^ rst;

  assign shamt   = alu_a[4:0];
  assign sltBit  = ($signed(alu_a) < $signed(alu_b));
  assign sltuBit = (alu_a < alu_b);

  always_comb begin
    alu_out = '0;
    case (alu_ctrl)
      ALU_ADD:   alu_out = alu_a + alu_b;
      ALU_SUB:   alu_out = alu_a - alu_b;
      ALU_AND:   alu_out = alu_a & alu_b;
      ALU_OR:    alu_out = alu_a | alu_b;
      ALU_XOR:   alu_out = alu_a ^ alu_b;
      ALU_NOR:   alu_out = ~(alu_a | alu_b);
      ALU_SLT:   alu_out = {{(DATA_W-1){1'b0}}, sltBit};
      ALU_SLTU:  alu_out = {{(DATA_W-1){1'b0}}, sltuBit};
      ALU_SLL:   alu_out = alu_b << shamt;
      ALU_SRL:   alu_out = alu_b >> shamt;
      ALU_SRA:   alu_out = $signed(alu_b) >>> shamt;
      ALU_LUI:   alu_out = alu_b << 16;
      ALU_PASSB: alu_out = alu_b;
      default:   alu_out = '0;
    endcase
  end

  branch_comp uBranchComp (
    .opA      (comp_a),
    .opB      (comp_b),
    .condOp   (comp_op),
    .condTrue (comp_true)
  );

  // Byte wins over half; halfwords use only be_addr[1], words ignore the address.
  always_comb begin
    be_out = BE_WORD;
    if (is_byte) begin
      be_out = BE_BYTE0 << be_addr;
    end else if (is_half) begin
      be_out = be_addr[1] ? BE_HALF_HI : BE_HALF_LO;
    end
  end

endmodule

// File: tb/tb_alu_comp_bectrl.sv
// Self-checking bench for alu_comp_bectrl: directed tables, reset transparency, random vs model.
module tb_alu_comp_bectrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_ctrl;
  logic [31:0] comp_a, comp_b;
  logic [2:0]  comp_op;
  logic        comp_true;
  logic [1:0]  be_addr;
  logic        is_half, is_byte;
  logic [3:0]  be_out;

  int nVec = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  alu_comp_bectrl #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
    .comp_a(comp_a), .comp_b(comp_b), .comp_op(comp_op), .comp_true(comp_true),
    .be_addr(be_addr), .is_half(is_half), .is_byte(is_byte), .be_out(be_out)
  );

  typedef struct { logic [31:0] a; logic [31:0] b; logic [3:0] ctrl; logic [31:0] exp; } aluVec_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic [2:0] op; logic exp; } cmpVec_t;
  typedef struct { logic [1:0] addr; logic half; logic isB; logic [3:0] exp; } beVec_t;

  aluVec_t aluTab[16];
  cmpVec_t cmpTab[13];
  beVec_t  beTab[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference ALU built from plain integer arithmetic on 64-bit values.
  function automatic logic [31:0] refAlu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint sa = longint'(signed'(a));
    longint sb = longint'(signed'(b));
    longint unsigned p2 = 1;
    longint q;
    for (int k = 0; k < int'(a % 32); k++) p2 = p2 * 2;
    case (op)
      4'd0:  return 32'(ua + ub);
      4'd1:  return 32'(ua + 64'h1_0000_0000 - ub);
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd7:  return (ua < ub) ? 32'd1 : 32'd0;
      4'd8:  return 32'(ub * p2);
      4'd9:  return 32'(ub / p2);
      4'd10: begin
        q = sb / longint'(p2);
        if (sb < 0 && (sb % longint'(p2)) != 0) q = q - 1;
        return 32'(q);
      end
      4'd11: return 32'(ub * 65536);
      4'd12: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic refCmp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    longint sa = longint'(signed'(a));
    case (op)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return sa <= 0;
      3'd3: return sa > 0;
      3'd4: return sa < 0;
      3'd5: return sa >= 0;
      default: return 1'b0;
    endcase
  endfunction

  // Enable every byte lane covered by an aligned access of the given size.
  function automatic logic [3:0] refBe(input logic [1:0] addr, input logic half, input logic isB);
    int size = isB ? 1 : (half ? 2 : 4);
    int start = (int'(addr) / size) * size;
    logic [3:0] m = '0;
    for (int i = 0; i < 4; i++) m[i] = (i >= start) && (i < start + size);
    return m;
  endfunction

  initial begin
    aluTab[0]  = '{32'h7FFFFFFF, 32'h00000001, 4'h0, 32'h80000000};
    aluTab[1]  = '{32'h7FFFFFFF, 32'h00000001, 4'h1, 32'h7FFFFFFE};
    aluTab[2]  = '{32'hFFFFFFFF, 32'h00000001, 4'h6, 32'h00000001};
    aluTab[3]  = '{32'hFFFFFFFF, 32'h00000001, 4'h7, 32'h00000000};
    aluTab[4]  = '{32'h00000004, 32'h80000010, 4'hA, 32'hF8000001};
    aluTab[5]  = '{32'h00000004, 32'h80000010, 4'h9, 32'h08000001};
    aluTab[6]  = '{32'h00000004, 32'h80000010, 4'h8, 32'h00000100};
    aluTab[7]  = '{32'hFFFFFFE0, 32'h80000010, 4'h8, 32'h80000010};
    aluTab[8]  = '{32'hFFFFFFE0, 32'h80000010, 4'hA, 32'h80000010};
    aluTab[9]  = '{32'h00000000, 32'h00001234, 4'hB, 32'h12340000};
    aluTab[10] = '{32'h00000000, 32'hDEADBEEF, 4'hC, 32'hDEADBEEF};
    aluTab[11] = '{32'h12345678, 32'hDEADBEEF, 4'hF, 32'h00000000};
    aluTab[12] = '{32'hF0F0F0F0, 32'hFF00FF00, 4'h2, 32'hF000F000};
    aluTab[13] = '{32'hF0F0F0F0, 32'hFF00FF00, 4'h3, 32'hFFF0FFF0};
    aluTab[14] = '{32'hF0F0F0F0, 32'hFF00FF00, 4'h4, 32'h0FF00FF0};
    aluTab[15] = '{32'hF0F0F0F0, 32'hFF00FF00, 4'h5, 32'h000F000F};

    cmpTab[0]  = '{32'h80000000, 32'h00000000, 3'd4, 1'b1};
    cmpTab[1]  = '{32'h80000000, 32'h00000000, 3'd5, 1'b0};
    cmpTab[2]  = '{32'h80000000, 32'h00000000, 3'd2, 1'b1};
    cmpTab[3]  = '{32'h80000000, 32'h00000000, 3'd3, 1'b0};
    cmpTab[4]  = '{32'h00000000, 32'h7FFFFFFF, 3'd2, 1'b1};
    cmpTab[5]  = '{32'h00000000, 32'h7FFFFFFF, 3'd5, 1'b1};
    cmpTab[6]  = '{32'h00000000, 32'hFFFFFFFF, 3'd3, 1'b0};
    cmpTab[7]  = '{32'h00000005, 32'h00000005, 3'd0, 1'b1};
    cmpTab[8]  = '{32'h00000005, 32'h00000005, 3'd1, 1'b0};
    cmpTab[9]  = '{32'h00000005, 32'h00000005, 3'd7, 1'b0};
    cmpTab[10] = '{32'h00000005, 32'h00000005, 3'd6, 1'b0};
    cmpTab[11] = '{32'h00000005, 32'h00000006, 3'd0, 1'b0};
    cmpTab[12] = '{32'h00000001, 32'hFFFFFFFF, 3'd3, 1'b1};

    beTab[0]  = '{2'd0, 1'b0, 1'b1, 4'b0001};
    beTab[1]  = '{2'd1, 1'b0, 1'b1, 4'b0010};
    beTab[2]  = '{2'd2, 1'b0, 1'b1, 4'b0100};
    beTab[3]  = '{2'd3, 1'b0, 1'b1, 4'b1000};
    beTab[4]  = '{2'd2, 1'b1, 1'b0, 4'b1100};
    beTab[5]  = '{2'd3, 1'b1, 1'b0, 4'b1100};
    beTab[6]  = '{2'd0, 1'b1, 1'b0, 4'b0011};
    beTab[7]  = '{2'd1, 1'b1, 1'b0, 4'b0011};
    beTab[8]  = '{2'd2, 1'b0, 1'b0, 4'b1111};
    beTab[9]  = '{2'd3, 1'b0, 1'b0, 4'b1111};
    beTab[10] = '{2'd2, 1'b1, 1'b1, 4'b0100};

    // Outputs follow inputs even while reset is held.
    rst = 1'b1;
    alu_a = '0; alu_b = '0; alu_ctrl = 4'h0;
    comp_a = '0; comp_b = '0; comp_op = 3'd0;
    be_addr = 2'd0; is_half = 1'b0; is_byte = 1'b0;
    @(negedge clk); #1;
    chk("rst_alu", alu_out, 32'h0);
    chk("rst_cmp", {31'b0, comp_true}, 32'h1);
    chk("rst_be", {28'b0, be_out}, 32'hF);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      alu_a = aluTab[i].a; alu_b = aluTab[i].b; alu_ctrl = aluTab[i].ctrl;
      #1 chk($sformatf("alu_tab[%0d]", i), alu_out, aluTab[i].exp);
    end
    for (int i = 0; i < 13; i++) begin
      comp_a = cmpTab[i].a; comp_b = cmpTab[i].b; comp_op = cmpTab[i].op;
      #1 chk($sformatf("cmp_tab[%0d]", i), {31'b0, comp_true}, {31'b0, cmpTab[i].exp});
    end
    for (int i = 0; i < 11; i++) begin
      be_addr = beTab[i].addr; is_half = beTab[i].half; is_byte = beTab[i].isB;
      #1 chk($sformatf("be_tab[%0d]", i), {28'b0, be_out}, {28'b0, beTab[i].exp});
    end

    // Three reset cycles with the arithmetic vectors applied each cycle.
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        alu_a = aluTab[i].a; alu_b = aluTab[i].b; alu_ctrl = aluTab[i].ctrl;
        #1 chk($sformatf("rst_cyc%0d_alu[%0d]", c, i), alu_out, aluTab[i].exp);
      end
    end
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 7) == 0);
      alu_a    = $urandom;
      alu_b    = $urandom;
      alu_ctrl = 4'($urandom_range(0, 15));
      comp_a   = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      comp_b   = ($urandom_range(0, 3) == 0) ? comp_a : $urandom;
      comp_op  = 3'($urandom_range(0, 7));
      be_addr  = 2'($urandom_range(0, 3));
      is_half  = 1'($urandom_range(0, 1));
      is_byte  = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("rnd%0d_alu op=%0d", n, alu_ctrl), alu_out, refAlu(alu_a, alu_b, alu_ctrl));
      chk($sformatf("rnd%0d_cmp op=%0d", n, comp_op), {31'b0, comp_true},
          {31'b0, refCmp(comp_a, comp_b, comp_op)});
      chk($sformatf("rnd%0d_be", n), {28'b0, be_out}, {28'b0, refBe(be_addr, is_half, is_byte)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
